// File: rtl/if_id_stage_pkg.sv
// ---- if_id_stage_pkg : shared IF/ID constants, fetch FSM encoding, field positions (rev 1.0) ----
`default_nettype none

package if_id_stage_pkg;

  // Fetch FSM encoding
  localparam logic [1:0] ST_REQ  = 2'd0;  // request outstanding
  localparam logic [1:0] ST_HOLD = 2'd1;  // word buffered during stall
  localparam logic [1:0] ST_DROP = 2'd2;  // discard response of redirected fetch

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int REG_W  = 5;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_stage_skid_buf.sv
// ---- if_skid_buf : one-entry buffer holding a fetched word while decode is stalled (rev 1.0) ----
`default_nettype none

module if_skid_buf
  import if_id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] data_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] data,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data  <= NOP;
      pc4   <= RESET_PC;
      valid <= 1'b0;
    end else if (load) begin
      data  <= data_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_id_stage.sv
// ---- if_id_stage : instruction fetch FSM with IF/ID pipeline register (rev 1.0) ----
`default_nettype none

module if_id_stage
  import if_id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        fwd_pc,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [4:0]  if_id_rs,
  output logic [4:0]  if_id_rt
);

  logic [1:0]  state, state_next;
  logic [31:0] pc, pc_next, pc_plus4, target, redirect_pc;
  logic        skid_load, skid_clear, skid_valid;
  logic [31:0] skid_data, skid_pc4;

  assign pc_plus4    = pc + 32'd4;
  assign redirect_pc = align_word(branch_target);
  assign imem_addr   = pc;
  assign if_id_rs    = if_id_instr[RS_LSB +: REG_W];
  assign if_id_rt    = if_id_instr[RT_LSB +: REG_W];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_REQ;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_REQ: begin
        if (fwd_pc && !imem_ack)                         state_next = ST_DROP;
        else if (!fwd_pc && !flush && imem_ack && stall) state_next = ST_HOLD;
      end
      ST_HOLD: if (fwd_pc || flush || !stall) state_next = ST_REQ;
      ST_DROP: if (imem_ack)                  state_next = ST_REQ;
      default:                                state_next = ST_REQ;
    endcase
  end

  // In DROP the PC keeps addressing the abandoned fetch; the redirect waits in target.
  always_comb begin
    imem_req   = !rst && (state != ST_HOLD);
    pc_next    = pc;
    skid_load  = 1'b0;
    skid_clear = flush || fwd_pc;
    case (state)
      ST_REQ: begin
        if (fwd_pc) begin
          if (imem_ack) pc_next = redirect_pc;
        end else if (!flush && imem_ack) begin
          pc_next   = pc_plus4;
          skid_load = stall;
        end
      end
      ST_HOLD: begin
        if (fwd_pc)      pc_next    = redirect_pc;
        else if (!stall) skid_clear = 1'b1;
      end
      ST_DROP: if (imem_ack) pc_next = fwd_pc ? redirect_pc : target;
      default: pc_next = pc;
    endcase
  end

  // A flushed word acked in REQ is not counted: PC stays put so it is refetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      target         <= RESET_PC;
      if_id_instr    <= NOP;
      if_id_pc_plus4 <= RESET_PC;
      if_id_valid    <= 1'b0;
    end else begin
      pc <= pc_next;
      if (fwd_pc) target <= redirect_pc;
      if (flush) begin
        if_id_instr <= NOP;
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if (fwd_pc) begin
          if_id_valid <= 1'b0;
        end else begin
          case (state)
            ST_REQ: begin
              if (imem_ack) begin
                if_id_instr    <= imem_data;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b1;
              end else begin
                if_id_valid <= 1'b0;
              end
            end
            ST_HOLD: begin
              if_id_instr    <= skid_data;
              if_id_pc_plus4 <= skid_pc4;
              if_id_valid    <= skid_valid;
            end
            default: if_id_valid <= 1'b0;
          endcase
        end
      end
    end
  end

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .data_in (imem_data),
    .pc4_in  (pc_plus4),
    .data    (skid_data),
    .pc4     (skid_pc4),
    .valid   (skid_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ---- tb_if_id_stage : directed scoreboard bench for if_id_stage (rev 1.0) ----
`default_nettype none

module tb_if_id_stage;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        clk = 1'b0;
  logic        rst, stall, flush, fwd_pc, imem_ack;
  logic [31:0] branch_target, imem_data;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_instr, if_id_pc_plus4;
  logic [4:0]  if_id_rs, if_id_rt;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  if_id_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .fwd_pc         (fwd_pc),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return 32'h8C0B_0000 | {16'h0000, addr[15:0]};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the fetch port, retire the IF/ID word decode consumes.
  task automatic step(input logic s, input logic f, input logic fw, input logic [31:0] bt,
                      input logic a, input logic keep, input logic exp_req,
                      input logic [31:0] exp_addr);
    exp_t e;
    stall = s; flush = f; fwd_pc = fw; branch_target = bt; imem_ack = a;
    #1;
    imem_data = a ? word_at(imem_addr) : 32'hDEAD_BEEF;
    chk1("imem_req", imem_req, exp_req);
    if (exp_req) chk32("imem_addr", imem_addr, exp_addr);
    if (a && keep) begin
      e.instr = word_at(exp_addr);
      e.pc4   = exp_addr + 32'd4;
      sb.push_back(e);
    end
    if (if_id_valid && f) begin
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (if_id_valid && !s) begin
      if (sb.size() == 0) begin
        chk32("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk32("if_id_instr", if_id_instr, e.instr);
        chk32("if_id_pc_plus4", if_id_pc_plus4, e.pc4);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; fwd_pc = 1'b0; imem_ack = 1'b0;
    branch_target = 32'h0; imem_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", if_id_valid, 1'b0);
    chk32("rst_instr", if_id_instr, 32'h0);
    chk32("rst_pc4", if_id_pc_plus4, 32'h0);
    rst = 1'b0;

    // ack every cycle: sequential fetch 0,4,8,C
    step(O, O, O, 32'h0, I, I, I, 32'h0000_0000);
    chk32("rt_field", {27'b0, if_id_rt}, {27'b0, 5'b01011});
    chk1("valid_after_ack", if_id_valid, 1'b1);
    step(O, O, O, 32'h0, I, I, I, 32'h0000_0004);
    step(O, O, O, 32'h0, I, I, I, 32'h0000_0008);
    step(O, O, O, 32'h0, I, I, I, 32'h0000_000C);

    // stall 3 cycles with ack in the first: word goes to skid buffer
    step(I, O, O, 32'h0, I, I, I, 32'h0000_0010);
    chk32("stall_hold_pc4", if_id_pc_plus4, 32'h0000_0010);
    step(I, O, O, 32'h0, O, O, O, 32'h0);
    step(I, O, O, 32'h0, O, O, O, 32'h0);
    chk32("stall_hold_pc4_3", if_id_pc_plus4, 32'h0000_0010);
    chk1("stall_hold_valid", if_id_valid, 1'b1);
    step(O, O, O, 32'h0, O, O, O, 32'h0);
    chk32("skid_out_pc4", if_id_pc_plus4, 32'h0000_0014);
    step(O, O, O, 32'h0, I, I, I, 32'h0000_0014);
    step(O, O, O, 32'h0, O, O, I, 32'h0000_0018);
    chk1("bubble_valid", if_id_valid, 1'b0);

    // redirect to 0x43 with ack delayed two cycles: old response dropped
    step(O, O, I, 32'h0000_0043, O, O, I, 32'h0000_0018);
    step(O, O, O, 32'h0, O, O, I, 32'h0000_0018);
    step(O, O, O, 32'h0, I, O, I, 32'h0000_0018);
    chk1("drop_valid", if_id_valid, 1'b0);
    step(O, O, O, 32'h0, I, I, I, 32'h0000_0040);
    step(O, O, O, 32'h0, O, O, I, 32'h0000_0044);

    // flush and stall in the same cycle
    step(O, O, O, 32'h0, I, I, I, 32'h0000_0044);
    step(I, I, O, 32'h0, O, O, I, 32'h0000_0048);
    chk32("flush_instr", if_id_instr, 32'h0);
    chk1("flush_valid", if_id_valid, 1'b0);
    step(O, O, O, 32'h0, I, I, I, 32'h0000_0048);
    step(O, O, O, 32'h0, O, O, I, 32'h0000_004C);

    // redirect to the top word and wrap
    step(O, O, I, 32'hFFFF_FFFC, I, O, I, 32'h0000_004C);
    step(O, O, O, 32'h0, I, I, I, 32'hFFFF_FFFC);
    chk32("wrap_pc4", if_id_pc_plus4, 32'h0000_0000);
    step(O, O, O, 32'h0, O, O, I, 32'h0000_0000);

    // reset with an unacked request outstanding
    step(O, O, O, 32'h0, I, I, I, 32'h0000_0000);
    rst = 1'b1; imem_ack = 1'b0;
    #1;
    chk1("mid_rst_req", imem_req, 1'b0);
    @(posedge clk); #1;
    sb.delete();
    chk1("mid_rst_valid", if_id_valid, 1'b0);
    chk32("mid_rst_instr", if_id_instr, 32'h0);
    chk32("mid_rst_pc4", if_id_pc_plus4, 32'h0);
    imem_ack = 1'b1; imem_data = 32'hBAD0_0000;
    @(posedge clk); #1;
    rst = 1'b0; imem_ack = 1'b0;
    chk1("late_ack_ignored", if_id_valid, 1'b0);
    step(O, O, O, 32'h0, I, I, I, 32'h0000_0000);
    step(O, O, O, 32'h0, O, O, I, 32'h0000_0004);
    chk32("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
